irq_response: RTL and testbench

IRQ_RESPONSE -- requirements
Module: irq_response

---
 rtl/irq_response.sv | 119 +++++++++++
 tb/tb_irq_response.sv | 137 +++++++++++++
 2 files changed

// File: rtl/irq_response.sv
// IRQ entry/return sequencer: saves the return context, switches to IRQ mode and
// vectors on a qualifying instruction boundary, and performs the LR-based return.
module irq_response #(
   parameter logic [4:0] IRQ_MODE = 5'b10010
) (
   input  logic        clk,
   input  logic        clr,
   input  logic        INT_irq,
   input  logic        instr_done,
   input  logic        ret_req,
   input  logic [31:0] CPSR_in,
   input  logic [31:0] SPSR_irq_in,
   input  logic [31:0] PC_in,
   output logic        INTA_irq,
   output logic [1:0]  PC_s,
   output logic        Write_PC,
   output logic [31:0] LR_irq_out,
   output logic        Write_LR_irq,
   output logic [31:0] SPSR_irq_out,
   output logic        Write_SPSR_irq,
   output logic [31:0] CPSR_out,
   output logic        Write_CPSR,
   output logic        stall
);

   typedef enum logic [2:0] {
      IDLE,
      SAVE,
      SWITCH,
      VECTOR,
      RESTORE
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [31:0] r_pc_cap;
   logic [31:0] r_cpsr_cap;
   logic        w_take;
   logic        w_ret;

   // Return wins over entry when both are requested at the same boundary.
   assign w_ret  = (r_state == IDLE) && instr_done && ret_req;
   assign w_take = (r_state == IDLE) && instr_done && !ret_req && INT_irq && !CPSR_in[7];

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_state    <= IDLE;
         r_pc_cap   <= '0;
         r_cpsr_cap <= '0;
      end else begin
         r_state <= w_next;
         if (w_take) begin
            r_pc_cap   <= PC_in;
            r_cpsr_cap <= CPSR_in;
         end
      end
   end

   // NOTE: every signal driven here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (w_ret)
               w_next = RESTORE;
            else if (w_take)
               w_next = SAVE;
         end
         SAVE:    w_next = SWITCH;
         SWITCH:  w_next = VECTOR;
         VECTOR:  w_next = IDLE;
         RESTORE: w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Moore outputs; data buses are held at zero outside the state that writes them.
   always_comb begin
      INTA_irq       = 1'b0;
      PC_s           = 2'b00;
      Write_PC       = 1'b0;
      LR_irq_out     = '0;
      Write_LR_irq   = 1'b0;
      SPSR_irq_out   = '0;
      Write_SPSR_irq = 1'b0;
      CPSR_out       = '0;
      Write_CPSR     = 1'b0;
      stall          = (r_state != IDLE);
      case (r_state)
         SAVE: begin
            Write_LR_irq   = 1'b1;
            LR_irq_out     = r_pc_cap + 32'd4;
            Write_SPSR_irq = 1'b1;
            SPSR_irq_out   = r_cpsr_cap;
         end
         SWITCH: begin
            // I set, F kept, T cleared, mode forced to IRQ.
            Write_CPSR = 1'b1;
            CPSR_out   = {r_cpsr_cap[31:8], 1'b1, r_cpsr_cap[6], 1'b0, IRQ_MODE};
         end
         VECTOR: begin
            Write_PC = 1'b1;
            PC_s     = 2'b11;
            INTA_irq = 1'b1;
         end
         RESTORE: begin
            Write_CPSR = 1'b1;
            CPSR_out   = SPSR_irq_in;
            Write_PC   = 1'b1;
            PC_s       = 2'b10;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_irq_response.sv
// Directed self-checking bench for irq_response: entry, masking, return priority,
// LR wrap, mid-sequence reset and T-bit clearing.
module tb_irq_response;

   logic        clk = 1'b0;
   logic        clr;
   logic        INT_irq, instr_done, ret_req;
   logic [31:0] CPSR_in, SPSR_irq_in, PC_in;
   logic        INTA_irq, Write_PC, Write_LR_irq, Write_SPSR_irq, Write_CPSR, stall;
   logic [1:0]  PC_s;
   logic [31:0] LR_irq_out, SPSR_irq_out, CPSR_out;

   int tests_run = 0;
   int tests_failed = 0;
   int inta_count = 0;

   irq_response dut (
      .clk(clk), .clr(clr), .INT_irq(INT_irq), .instr_done(instr_done),
      .ret_req(ret_req), .CPSR_in(CPSR_in), .SPSR_irq_in(SPSR_irq_in), .PC_in(PC_in),
      .INTA_irq(INTA_irq), .PC_s(PC_s), .Write_PC(Write_PC),
      .LR_irq_out(LR_irq_out), .Write_LR_irq(Write_LR_irq),
      .SPSR_irq_out(SPSR_irq_out), .Write_SPSR_irq(Write_SPSR_irq),
      .CPSR_out(CPSR_out), .Write_CPSR(Write_CPSR), .stall(stall)
   );

   always #5 clk = ~clk;

   always @(posedge INTA_irq) inta_count++;

   // {INTA, PC_s, Write_PC, Write_LR, Write_SPSR, Write_CPSR, stall}
   function automatic logic [31:0] ctl();
      return {24'd0, INTA_irq, PC_s, Write_PC, Write_LR_irq, Write_SPSR_irq, Write_CPSR, stall};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int base;
      clr = 1'b1; INT_irq = 0; instr_done = 0; ret_req = 0;
      CPSR_in = '0; SPSR_irq_in = '0; PC_in = '0;
      #1;
      check("reset_ctl", ctl(), 32'h0);
      check("reset_data", LR_irq_out | SPSR_irq_out | CPSR_out, 32'h0);
      @(negedge clk); clr = 1'b0;

      // Basic entry
      INT_irq = 1; CPSR_in = 32'h10; PC_in = 32'h100; instr_done = 1;
      base = inta_count;
      step(); instr_done = 0;
      check("save_ctl", ctl(), 32'h0D);
      check("save_lr", LR_irq_out, 32'h104);
      check("save_spsr", SPSR_irq_out, 32'h10);
      step();
      check("switch_ctl", ctl(), 32'h03);
      check("switch_cpsr", CPSR_out, 32'h92);
      step();
      check("vector_ctl", ctl(), 32'hF1);
      step();
      check("back_idle_ctl", ctl(), 32'h0);
      check("entry_inta_once", inta_count - base, 1);

      // No boundary: stays idle even with request pending and I clear
      for (int i = 0; i < 3; i++) begin
         step();
         check("no_boundary_stall", {31'd0, stall}, 0);
      end

      // Masked by CPSR I bit
      CPSR_in = 32'h90; instr_done = 1; base = inta_count;
      for (int i = 0; i < 10; i++) begin
         step();
         check("masked_ctl", ctl(), 32'h0);
      end
      check("masked_no_inta", inta_count - base, 0);

      // Return wins over entry at the same boundary
      CPSR_in = 32'h10; ret_req = 1; SPSR_irq_in = 32'h6000_0010; base = inta_count;
      step(); ret_req = 0; instr_done = 0;
      check("restore_ctl", ctl(), 32'h53);
      check("restore_cpsr", CPSR_out, 32'h6000_0010);
      step();
      check("restore_idle", ctl(), 32'h0);
      check("restore_no_inta", inta_count - base, 0);

      // LR wraps modulo 2^32
      PC_in = 32'hFFFF_FFFC; instr_done = 1;
      step(); instr_done = 0;
      check("wrap_lr", LR_irq_out, 32'h0);
      check("wrap_spsr", SPSR_irq_out, 32'h10);
      step(); step(); step();
      check("wrap_idle", ctl(), 32'h0);

      // Reset during SWITCH aborts without acknowledge, entry re-taken afterwards
      PC_in = 32'h200; instr_done = 1; base = inta_count;
      step(); instr_done = 0;
      step();
      check("abort_in_switch", ctl(), 32'h03);
      #2 clr = 1'b1;
      #1;
      check("abort_ctl_zero", ctl(), 32'h0);
      check("abort_cpsr_zero", CPSR_out, 32'h0);
      @(negedge clk); @(negedge clk);
      check("abort_no_inta", inta_count - base, 0);
      clr = 1'b0; instr_done = 1;
      step(); instr_done = 0;
      check("retake_ctl", ctl(), 32'h0D);
      check("retake_lr", LR_irq_out, 32'h204);
      step(); step();
      check("retake_vector", ctl(), 32'hF1);
      step();
      check("retake_inta_once", inta_count - base, 1);

      // Thumb bit cleared on entry
      CPSR_in = 32'h30; instr_done = 1;
      step(); instr_done = 0;
      check("thumb_spsr", SPSR_irq_out, 32'h30);
      step();
      check("thumb_cpsr", CPSR_out, 32'h92);
      step(); step();
      check("thumb_idle", ctl(), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
